// File: rtl/serial_arbiter.sv
// Two-channel TX arbiter in front of a polled serial port: per-channel byte FIFOs,
// continuous status polling, RX serviced ahead of TX, round-robin between TX channels.
module serial_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       io_addr,
  output logic [7:0] io_wdata,
  output logic       io_rd,
  output logic       io_we,
  output logic       io_ce,
  input  logic [7:0] io_rdata,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, POLL, STAT, RXRD, RXCAP, TXWR} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rxd_q, rxd_d;

  logic [7:0]    mem_q    [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW:0]   cnt_q    [2];
  logic [7:0]    in_data  [2];
  logic [1:0]    in_valid, push, pop, nempty, full;
  logic [7:0]    head;

  assign in_data[0] = s0_data;
  assign in_data[1] = s1_data;
  assign in_valid   = {s1_valid, s0_valid};
  assign s0_ready   = ~full[0];
  assign s1_ready   = ~full[1];
  assign head       = mem_q[grant_q][rd_ptr_q[grant_q]];
  assign busy       = (nempty != 2'b00) || (state_q != IDLE);

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]   = (cnt_q[c] == FULL_CNT);
      nempty[c] = (cnt_q[c] != '0);
      push[c]   = in_valid[c] & ~full[c];
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        if (push[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
        else if (!push[c] && pop[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= in_data[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wdata_q <= '0;
      rxd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      rxd_q   <= rxd_d;
    end
  end

  // io_wdata and rx_data show the live byte in their strobe cycle and hold it afterwards
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    rxd_d    = rxd_q;
    pop      = 2'b00;
    io_rd    = 1'b0;
    io_we    = 1'b0;
    io_ce    = 1'b0;
    io_addr  = 1'b0;
    io_wdata = wdata_q;
    rx_data  = rxd_q;
    rx_valid = 1'b0;
    case (state_q)
      IDLE: state_d = POLL;
      POLL: begin
        io_rd   = 1'b1;
        io_ce   = 1'b1;
        state_d = STAT;
      end
      STAT: begin
        if (io_rdata[0]) begin
          state_d = RXRD;
        end else if (io_rdata[1] && (nempty != 2'b00)) begin
          state_d = TXWR;
          grant_d = (nempty == 2'b11) ? ~last_q : nempty[1];
        end else begin
          state_d = IDLE;
        end
      end
      RXRD: begin
        io_rd   = 1'b1;
        io_ce   = 1'b1;
        io_addr = 1'b1;
        state_d = RXCAP;
      end
      RXCAP: begin
        rx_data  = io_rdata;
        rxd_d    = io_rdata;
        rx_valid = 1'b1;
        state_d  = IDLE;
      end
      TXWR: begin
        io_we          = 1'b1;
        io_ce          = 1'b1;
        io_addr        = 1'b1;
        io_wdata       = head;
        wdata_d        = head;
        pop[grant_q]   = 1'b1;
        last_d         = grant_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_arbiter.sv
// Bench for serial_arbiter: acts as the serial port, keeps a bus-cycle timeline and
// per-channel byte queues, and scoreboards every written and received byte.
module tb_serial_arbiter;
  localparam int DEPTH = 4;
  localparam int K_IDLE = 0, K_POLL = 1, K_STAT = 2, K_RXRD = 3, K_RXCAP = 4, K_TXWR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s0_data, s1_data, rx_data, io_wdata, io_rdata;
  logic       s0_valid, s0_ready, s1_valid, s1_ready, rx_valid;
  logic       io_addr, io_rd, io_we, io_ce, busy;

  serial_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_we(io_we), .io_ce(io_ce),
    .io_rdata(io_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] q0[$], q1[$], dq0[$], dq1[$], exp_wr[$], exp_rx[$];
  int   sched[$];
  logic last_grant, stat_rx, stat_tx;
  logic [7:0] last_wd, last_rx, pend_rx, rdata_nxt;
  int   tdre_pct = 100, rx_pct = 0, off_pct = 0, rst_hold = 0;
  bit   rand_mode = 0, do_rst = 0, arm_rst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); exp_wr.delete(); exp_rx.delete(); sched.delete();
    sched.push_back(K_IDLE); sched.push_back(K_POLL); sched.push_back(K_STAT);
    last_grant = 1'b1; last_wd = '0; last_rx = '0; rdata_nxt = '0;
  endtask

  task automatic sched_add(input int a, input int b, input int c, input int d, input int e);
    if (a >= 0) sched.push_back(a);
    if (b >= 0) sched.push_back(b);
    sched.push_back(c); sched.push_back(d); sched.push_back(e);
  endtask

  // Model step, evaluated mid-cycle with all inputs and outputs stable
  task automatic step();
    int kind, ch;
    logic r0, r1;
    logic [31:0] rnd;
    rnd = $urandom;
    if (reset) begin
      check("reset_bus", {io_rd, io_we, io_ce, io_addr, rx_valid, busy}, 6'b0);
      check("reset_data", {io_wdata, rx_data}, 16'h0);
      check("reset_ready", {s0_ready, s1_ready}, 2'b11);
      model_reset();
      return;
    end
    if (sched.size() == 0) begin
      $display("FAIL timeline: got empty expected entry");
      $fatal(1, "timeline underflow");
    end
    kind = sched.pop_front();
    r0 = (q0.size() < DEPTH);
    r1 = (q1.size() < DEPTH);
    check("s0_ready", s0_ready, r0);
    check("s1_ready", s1_ready, r1);
    check("busy", busy, (kind != K_IDLE) || q0.size() != 0 || q1.size() != 0);
    check("bus", {io_rd, io_we, io_ce, io_addr, rx_valid},
          {kind == K_POLL || kind == K_RXRD, kind == K_TXWR,
           kind == K_POLL || kind == K_RXRD || kind == K_TXWR,
           kind == K_RXRD || kind == K_TXWR, kind == K_RXCAP});
    if (kind != K_TXWR)  check("wdata_hold", io_wdata, last_wd);
    if (kind != K_RXCAP) check("rxdata_hold", rx_data, last_rx);
    rdata_nxt = rnd[15:8];
    case (kind)
      K_POLL: begin
        stat_rx   = ($urandom % 100) < rx_pct;
        stat_tx   = ($urandom % 100) < tdre_pct;
        rdata_nxt = {rnd[5:0], stat_tx, stat_rx};
      end
      K_STAT: begin
        if (stat_rx) sched_add(K_RXRD, K_RXCAP, K_IDLE, K_POLL, K_STAT);
        else if (stat_tx && (q0.size() != 0 || q1.size() != 0)) begin
          if (q0.size() != 0 && q1.size() != 0) ch = last_grant ? 0 : 1;
          else ch = (q1.size() != 0) ? 1 : 0;
          last_grant = ch[0];
          exp_wr.push_back(ch == 1 ? q1[0] : q0[0]);
          sched_add(-1, K_TXWR, K_IDLE, K_POLL, K_STAT);
        end else sched_add(-1, -1, K_IDLE, K_POLL, K_STAT);
      end
      K_RXRD: begin
        pend_rx   = rnd[23:16];
        rdata_nxt = pend_rx;
        exp_rx.push_back(pend_rx);
      end
      K_RXCAP: last_rx = pend_rx;
      K_TXWR: begin
        if (last_grant) last_wd = q1.pop_front();
        else            last_wd = q0.pop_front();
      end
      default: ;
    endcase
    if (s0_valid && r0) begin
      q0.push_back(s0_data);
      if (dq0.size() != 0) void'(dq0.pop_front());
    end
    if (s1_valid && r1) begin
      q1.push_back(s1_data);
      if (dq1.size() != 0) void'(dq1.pop_front());
    end
  endtask

  task automatic cycle();
    logic [31:0] rnd;
    @(posedge clk);
    #1;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) reset = 1'b0;
    end
    if (do_rst || (arm_rst && !reset && sched.size() != 0 && sched[0] == K_TXWR &&
                   (q0.size() + q1.size()) >= 3)) begin
      reset = 1'b1; rst_hold = 1; do_rst = 0; arm_rst = 0;
    end
    rnd = $urandom;
    s0_data = rnd[7:0]; s1_data = rnd[15:8];
    s0_valid = 1'b0; s1_valid = 1'b0;
    if (dq0.size() != 0) begin s0_valid = 1'b1; s0_data = dq0[0]; end
    else if (rand_mode) s0_valid = ($urandom % 100) < off_pct;
    if (dq1.size() != 0) begin s1_valid = 1'b1; s1_data = dq1[0]; end
    else if (rand_mode) s1_valid = ($urandom % 100) < off_pct;
    io_rdata = rdata_nxt;
    @(negedge clk);
    step();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Scoreboard monitor: every write/receive must match the next expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && io_we) begin
        if (exp_wr.size() == 0) begin
          failures++; checks++;
          $display("FAIL tx_byte: got %0h expected no write", io_wdata);
        end else check("tx_byte", io_wdata, exp_wr.pop_front());
      end
      if (!reset && rx_valid) begin
        if (exp_rx.size() == 0) begin
          failures++; checks++;
          $display("FAIL rx_byte: got %0h expected no pulse", rx_data);
        end else check("rx_byte", rx_data, exp_rx.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    reset = 1'b1; rst_hold = 2;
    s0_valid = 0; s1_valid = 0; s0_data = 0; s1_data = 0; io_rdata = 0;
    model_reset();
    run(4);
    // single byte
    dq0.push_back(8'h41); run(12);
    // round robin from a fresh reset
    do_rst = 1; run(1);
    dq0.push_back(8'hA0); dq0.push_back(8'hA1);
    dq1.push_back(8'hB0); dq1.push_back(8'hB1);
    run(25);
    // RX priority with both queues loaded
    rx_pct = 100;
    dq0.push_back(8'h11); dq0.push_back(8'h22); dq1.push_back(8'h33);
    run(12);
    rx_pct = 0; run(20);
    // backpressure on channel 1
    tdre_pct = 0;
    for (int i = 0; i < DEPTH + 2; i++) dq1.push_back(8'hC0 + 8'(i));
    run(DEPTH + 12);
    tdre_pct = 100; run(60);
    // bit 7 pass-through
    dq0.push_back(8'hFF); dq1.push_back(8'h80); run(15);
    // reset in the middle of a write with three bytes queued
    tdre_pct = 0;
    dq0.push_back(8'h01); dq0.push_back(8'h02); dq1.push_back(8'h03);
    run(8);
    tdre_pct = 100; arm_rst = 1; run(25);
    // randomized traffic
    rand_mode = 1;
    for (int b = 0; b < 20; b++) begin
      tdre_pct = $urandom_range(0, 100);
      rx_pct   = $urandom_range(0, 60);
      off_pct  = $urandom_range(0, 100);
      if ($urandom_range(0, 9) == 0) do_rst = 1;
      run(150);
    end
    // drain
    rand_mode = 0; rx_pct = 0; tdre_pct = 100;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 300) begin
      cycle(); guard++;
    end
    run(8);
    check("drain_q", q0.size() + q1.size(), 0);
    check("drain_wr", exp_wr.size(), 0);
    check("drain_rx", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
